img_loader: RTL and testbench
=============================

IMG_LOADER -- requirements
Module: img_loader

Interface
REQ-001 The block SHALL have parameter PIX_W, default 8, giving the pixel width in bits.
REQ-002 The block SHALL have parameter IMG_DIM, default 9, giving the square frame side in pixels, so the frame width is PIX_W*IMG_DIM*IMG_DIM = 648.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pix_in  input  PIX_W  incoming pixel, raster order.
REQ-006 pix_valid  input  1  pix_in is valid this cycle.
REQ-007 pix_sof  input  1  marks the first pixel of a frame; qualified by pix_valid.
REQ-008 pix_ready  output  1  the block can accept a pixel; a transfer occurs when pix_valid and pix_ready are both high.
REQ-009 frame_out  output  648  packed frame; pixel k = 9*row + col sits at bits [8k+7:8k].
REQ-010 frame_valid  output  1  frame_out holds a complete frame.
REQ-011 frame_ack  input  1  the consumer has taken frame_out; qualified by frame_valid.
REQ-012 sof_err  output  1  one-cycle pulse on any framing violation.

Function
REQ-013 The block SHALL have write-side states IDLE, FILL and FULL, plus a 7-bit pixel index idx in the range 0..80.
REQ-014 In IDLE, a transfer with pix_sof=1 SHALL write pixel 0, set idx=1 and move to FILL.
REQ-015 In IDLE, a transfer with pix_sof=0 SHALL drop the pixel and pulse sof_err, and the state SHALL stay IDLE.
REQ-016 In FILL, a transfer with pix_sof=0 SHALL write pixel idx and increment idx.
REQ-017 In FILL, a transfer with pix_sof=1 SHALL pulse sof_err, discard the partial frame and restart with this pixel as pixel 0 (idx=1).
REQ-018 When pixel 80 is written, frame_valid SHALL be high on the next cycle, with state FULL and idx reset to 0.
REQ-019 Latency: the first cycle with frame_valid high SHALL be exactly one cycle after the 81st accepted transfer.
REQ-020 frame_out SHALL be stable while frame_valid is high, and frame_valid SHALL hold until frame_ack is sampled high.
REQ-021 In the cycle frame_ack is sampled, the block SHALL return to IDLE, with frame_valid low and pix_ready high on the next cycle.
REQ-022 frame_ack while frame_valid is low SHALL be ignored.
REQ-023 pix_ready SHALL be low only in FULL, and it SHALL be a pure function of registered state.
REQ-024 Unused frame_out bits SHALL not exist; all 648 bits carry pixel data.

Reset
REQ-025 On rst=1 at a clock edge: state SHALL be IDLE, idx SHALL be 0, frame_valid SHALL be 0, sof_err SHALL be 0, pix_ready SHALL be 1 after reset, and frame_out SHALL be all-zero.
REQ-026 Reset asserted mid-FILL or mid-FULL SHALL discard all buffered pixels with no frame_valid output.
REQ-027 rst SHALL take priority over pix_valid and frame_ack in the same cycle.

Configuration
REQ-028 With the macro IMG_LOADER_DOUBLE_BUF_EN defined, the block SHALL contain a second 648-bit back buffer.
REQ-029 With IMG_LOADER_DOUBLE_BUF_EN, while frame_valid is high, filling SHALL continue into the back buffer.
REQ-030 With IMG_LOADER_DOUBLE_BUF_EN, pix_ready SHALL go low only when the back buffer is complete and the front buffer is not yet acked.
REQ-031 With IMG_LOADER_DOUBLE_BUF_EN, on frame_ack with a complete back buffer, the buffers SHALL swap and frame_valid SHALL stay high with the new frame on the next cycle.
REQ-032 With IMG_LOADER_DOUBLE_BUF_EN, on frame_ack with a partial back buffer, filling SHALL continue and frame_valid SHALL drop.
REQ-033 Without IMG_LOADER_DOUBLE_BUF_EN, the block SHALL have a single buffer and behave as in REQ-013..REQ-024.

Structure
REQ-034 A shared package img_pkg SHALL hold PIX_W, IMG_DIM, the frame width constant (648), the pixel-count constant (81) and the loader state enum.
REQ-035 Frame assembly SHALL be a sub-module frame_buf (write-index plus data into a packed 648-bit register), instantiated once, or twice with IMG_LOADER_DOUBLE_BUF_EN.

Verification
REQ-036 Stream pixels 0..80 with value = index, sof on the first, then hold frame_ack low -> frame_valid high 1 cycle after the 81st transfer, frame_out[7:0]=0x00, [647:640]=0x50, pix_ready=0.
REQ-037 Same stream with pix_valid toggling every other cycle -> identical frame_out; frame_valid 1 cycle after the last transfer.
REQ-038 Send 20 pixels, then pix_sof with value 0xAA, then 80 pixels -> sof_err pulse exactly once, frame_out[7:0]=0xAA.
REQ-039 Pixel without sof in IDLE -> sof_err pulse, pixel dropped, idx stays 0.
REQ-040 Assert rst after 40 pixels -> frame_valid never rises; the next full frame loads correctly.
REQ-041 With IMG_LOADER_DOUBLE_BUF_EN, two back-to-back frames and frame_ack delayed 100 cycles -> no pix_ready drop until the second frame completes; after frame_ack, frame_out equals the second frame and frame_valid stays high.

Source files
------------

// File: rtl/img_pkg.sv
// img_pkg: constants and types shared by the image loader files.
//
// Contents:
//   PIX_W, IMG_DIM  default pixel width and square frame side
//   NPIX            pixel count per frame (81)
//   FRAME_W         packed frame width in bits (648)
//   IDX_W           width of the write pixel index (7)
//   ld_state_t      write-side state of the loader
package img_pkg;

  localparam int PIX_W   = 8;
  localparam int IMG_DIM = 9;
  localparam int NPIX    = IMG_DIM * IMG_DIM;
  localparam int FRAME_W = PIX_W * NPIX;
  localparam int IDX_W   = $clog2(NPIX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } ld_state_t;

endpackage

// File: rtl/frame_buf.sv
// frame_buf: packed frame register written one pixel at a time.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, clears the whole frame
//   wr_en    write pixel wr_idx this cycle
//   wr_idx   pixel index 0..NPIX-1 (pixel k lives at [PIX_W*k +: PIX_W])
//   wr_data  pixel value
//   frame    packed frame contents
module frame_buf #(
  parameter int PIX_W = img_pkg::PIX_W,
  parameter int NPIX  = img_pkg::NPIX,
  parameter int IDX_W = img_pkg::IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [PIX_W-1:0]      wr_data,
  output logic [PIX_W*NPIX-1:0] frame
);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame <= '0;
    end else if (wr_en) begin
      frame[int'(wr_idx)*PIX_W +: PIX_W] <= wr_data;
    end
  end

endmodule

// File: rtl/img_loader.sv
// img_loader: assembles a raster pixel stream into one packed square frame.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   pix_in       incoming pixel (raster order)
//   pix_valid    pix_in valid this cycle
//   pix_sof      first pixel of a frame, qualified by pix_valid
//   pix_ready    block can accept a pixel (transfer = pix_valid & pix_ready)
//   frame_out    packed frame, pixel k = IMG_DIM*row + col at [PIX_W*k +: PIX_W]
//   frame_valid  frame_out holds a complete frame
//   frame_ack    consumer took frame_out, qualified by frame_valid
//   sof_err      one-cycle pulse on a framing violation
//
// Build option:
//   IMG_LOADER_DOUBLE_BUF_EN  adds a back buffer so filling continues while
//                             the front frame waits for frame_ack.
module img_loader
  import img_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int IMG_DIM = 9
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PIX_W-1:0]                 pix_in,
  input  logic                             pix_valid,
  input  logic                             pix_sof,
  output logic                             pix_ready,
  output logic [PIX_W*IMG_DIM*IMG_DIM-1:0] frame_out,
  output logic                             frame_valid,
  input  logic                             frame_ack,
  output logic                             sof_err
);

  localparam int NP = IMG_DIM * IMG_DIM;
  localparam int IW = $clog2(NP);
  localparam logic [IW-1:0] LAST_IDX = IW'(NP - 1);

  ld_state_t     state;
  logic [IW-1:0] idx;
  logic          xfer;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic          last_pix;
  logic          fv_ack;

  // FULL is the only state that refuses pixels; decoded straight from the
  // state register so pix_ready never depends on the inputs.
  assign pix_ready = (state != ST_FULL);
  assign xfer      = pix_valid & pix_ready;

  // A sof pixel always lands at index 0; a non-sof pixel is only stored
  // while a frame is in progress (it is dropped in IDLE).
  assign wr_en    = xfer & (pix_sof | (state == ST_FILL));
  assign wr_idx   = pix_sof ? '0 : idx;
  assign last_pix = wr_en & ~pix_sof & (idx == LAST_IDX);
  assign fv_ack   = frame_valid & frame_ack;

`ifndef IMG_LOADER_DOUBLE_BUF_EN

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      frame_valid <= 1'b0;
      sof_err     <= 1'b0;
    end else begin
      sof_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            if (pix_sof) begin
              idx   <= IW'(1);
              state <= ST_FILL;
            end else begin
              sof_err <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (xfer) begin
            if (pix_sof) begin
              // Partial frame abandoned; this pixel already went to slot 0.
              sof_err <= 1'b1;
              idx     <= IW'(1);
            end else if (last_pix) begin
              idx         <= '0;
              state       <= ST_FULL;
              frame_valid <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        ST_FULL: begin
          if (fv_ack) begin
            state       <= ST_IDLE;
            frame_valid <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  frame_buf #(
    .PIX_W (PIX_W),
    .NPIX  (NP),
    .IDX_W (IW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (pix_in),
    .frame   (frame_out)
  );

`else

  localparam int FW = PIX_W * NP;

  // front selects which buffer is presented; the other one is filled.
  logic          front;
  logic [FW-1:0] buf0;
  logic [FW-1:0] buf1;

  // Here FULL means the back buffer is complete while the front frame is
  // still unacknowledged; a completed frame is presented immediately when
  // the front is free (or being acked in the same cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      frame_valid <= 1'b0;
      sof_err     <= 1'b0;
      front       <= 1'b0;
    end else begin
      sof_err <= 1'b0;
      if (fv_ack) begin
        frame_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            if (pix_sof) begin
              idx   <= IW'(1);
              state <= ST_FILL;
            end else begin
              sof_err <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (xfer) begin
            if (pix_sof) begin
              sof_err <= 1'b1;
              idx     <= IW'(1);
            end else if (last_pix) begin
              idx <= '0;
              if (!frame_valid || fv_ack) begin
                front       <= ~front;
                frame_valid <= 1'b1;
                state       <= ST_IDLE;
              end else begin
                state <= ST_FULL;
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        ST_FULL: begin
          if (fv_ack) begin
            front       <= ~front;
            frame_valid <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  frame_buf #(
    .PIX_W (PIX_W),
    .NPIX  (NP),
    .IDX_W (IW)
  ) u_buf0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en & front),
    .wr_idx  (wr_idx),
    .wr_data (pix_in),
    .frame   (buf0)
  );

  frame_buf #(
    .PIX_W (PIX_W),
    .NPIX  (NP),
    .IDX_W (IW)
  ) u_buf1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en & ~front),
    .wr_idx  (wr_idx),
    .wr_data (pix_in),
    .frame   (buf1)
  );

  assign frame_out = front ? buf1 : buf0;

`endif

endmodule

// File: tb/tb_img_loader.sv
// tb_img_loader: self-checking bench for img_loader.
// Expected frames are pushed to a queue as they are streamed in and popped
// when the DUT presents a frame. Honours IMG_LOADER_DOUBLE_BUF_EN.
module tb_img_loader;

  localparam int PW  = 8;
  localparam int DIM = 9;
  localparam int NP  = DIM * DIM;
  localparam int FW  = PW * NP;

`ifdef IMG_LOADER_DOUBLE_BUF_EN
  localparam logic RDY_WHEN_HELD = 1'b1;
`else
  localparam logic RDY_WHEN_HELD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_sof;
  logic          pix_ready;
  logic [FW-1:0] frame_out;
  logic          frame_valid;
  logic          frame_ack;
  logic          sof_err;

  always #5 clk = ~clk;

  img_loader #(
    .PIX_W   (PW),
    .IMG_DIM (DIM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_ready   (pix_ready),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .sof_err     (sof_err)
  );

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] exp_f;
  logic [FW-1:0] last_frame;
  int n_cmp = 0;
  int n_bad = 0;
  int sof_err_cnt = 0;
  int fv_rise_cnt = 0;
  int rdy_low_cnt = 0;
  logic fv_d = 1'b0;

  // Event counters sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (sof_err === 1'b1) sof_err_cnt++;
    if (frame_valid === 1'b1 && fv_d !== 1'b1) fv_rise_cnt++;
    if (pix_ready === 1'b0) rdy_low_cnt++;
    fv_d = frame_valid;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [PW-1:0] v, input logic s);
    bit acc;
    acc = 1'b0;
    pix_in    = v;
    pix_sof   = s;
    pix_valid = 1'b1;
    for (int w = 0; w < 300 && !acc; w++) begin
      acc = (pix_ready === 1'b1);
      tick();
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL send_pix_timeout: pix_ready=%b required 1", pix_ready);
    end
  endtask

  task automatic send_frame(input logic [FW-1:0] f, input bit toggle, output bit fv_early);
    fv_early = 1'b0;
    exp_q.push_back(f);
    for (int k = 0; k < NP; k++) begin
      if (k == NP - 1 && frame_valid === 1'b1) fv_early = 1'b1;
      send_pix(f[k*PW +: PW], k == 0);
      if (toggle && k != NP - 1) begin
        pix_valid = 1'b0;
        tick();
      end
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_valid = 1'b1; pix_sof = 1'b1; pix_in = 8'hFF; frame_ack = 1'b1;
    tick();
    tick();
    rst = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; frame_ack = 1'b0;
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_fv: got %b want 0", frame_valid); end
    n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_ready: got %b want 1", pix_ready); end
    n_cmp++; if (sof_err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_sof_err: got %b want 0", sof_err); end
    n_cmp++; if (frame_out !== '0) begin n_bad++; $display("[TB] FAIL reset_frame: got %h want 0", frame_out); end
    last_frame = '0;
  endtask

  task automatic test_stream();
    logic [FW-1:0] f;
    bit early;
    // ack while nothing is presented must be ignored
    do_ack();
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL stray_ack_fv: got %b want 0", frame_valid); end
    n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL stray_ack_ready: got %b want 1", pix_ready); end
    for (int k = 0; k < NP; k++) f[k*PW +: PW] = PW'(k);
    send_frame(f, 1'b0, early);
    n_cmp++; if (early !== 1'b0) begin n_bad++; $display("[TB] FAIL stream_early: fv before last transfer got %b want 0", early); end
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL stream_fv: got %b want 1", frame_valid); end
    n_cmp++; if (pix_ready !== RDY_WHEN_HELD) begin n_bad++; $display("[TB] FAIL stream_ready: got %b want %b", pix_ready, RDY_WHEN_HELD); end
    exp_f = exp_q.pop_front();
    n_cmp++; if (frame_out !== exp_f) begin n_bad++; $display("[TB] FAIL stream_frame: got %h want %h", frame_out, exp_f); end
    n_cmp++; if (frame_out[7:0] !== 8'h00) begin n_bad++; $display("[TB] FAIL stream_pix0: got %h want 00", frame_out[7:0]); end
    n_cmp++; if (frame_out[647:640] !== 8'h50) begin n_bad++; $display("[TB] FAIL stream_pix80: got %h want 50", frame_out[647:640]); end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL hold_fv: got %b want 1", frame_valid); end
    n_cmp++; if (frame_out !== exp_f) begin n_bad++; $display("[TB] FAIL hold_frame: got %h want %h", frame_out, exp_f); end
    do_ack();
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL ack_fv: got %b want 0", frame_valid); end
    n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL ack_ready: got %b want 1", pix_ready); end
    last_frame = exp_f;
  endtask

  task automatic test_toggle();
    logic [FW-1:0] f;
    bit early;
    for (int k = 0; k < NP; k++) f[k*PW +: PW] = PW'(k);
    send_frame(f, 1'b1, early);
    n_cmp++; if (early !== 1'b0) begin n_bad++; $display("[TB] FAIL toggle_early: got %b want 0", early); end
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL toggle_fv: got %b want 1", frame_valid); end
    exp_f = exp_q.pop_front();
    n_cmp++; if (frame_out !== exp_f) begin n_bad++; $display("[TB] FAIL toggle_frame: got %h want %h", frame_out, exp_f); end
    do_ack();
    last_frame = exp_f;
  endtask

  task automatic test_sof_restart();
    logic [FW-1:0] f;
    int base;
    base = sof_err_cnt;
    for (int k = 0; k < 20; k++) send_pix(PW'(k + 8'h10), k == 0);
    f[PW-1:0] = 8'hAA;
    for (int k = 1; k < NP; k++) f[k*PW +: PW] = PW'(k);
    exp_q.push_back(f);
    send_pix(8'hAA, 1'b1);
    for (int k = 1; k < NP; k++) send_pix(PW'(k), 1'b0);
    pix_valid = 1'b0; pix_sof = 1'b0;
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL restart_fv: got %b want 1", frame_valid); end
    tick();
    n_cmp++; if (sof_err_cnt - base !== 1) begin n_bad++; $display("[TB] FAIL restart_sof_err: got %0d pulses want 1", sof_err_cnt - base); end
    exp_f = exp_q.pop_front();
    n_cmp++; if (frame_out !== exp_f) begin n_bad++; $display("[TB] FAIL restart_frame: got %h want %h", frame_out, exp_f); end
    n_cmp++; if (frame_out[7:0] !== 8'hAA) begin n_bad++; $display("[TB] FAIL restart_pix0: got %h want aa", frame_out[7:0]); end
    do_ack();
    last_frame = exp_f;
  endtask

  task automatic test_no_sof();
    logic [FW-1:0] f;
    bit early;
    int base;
    base = sof_err_cnt;
    pix_in = 8'h33; pix_sof = 1'b0; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    n_cmp++; if (sof_err_cnt - base !== 1) begin n_bad++; $display("[TB] FAIL nosof_err: got %0d pulses want 1", sof_err_cnt - base); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL nosof_fv: got %b want 0", frame_valid); end
    n_cmp++; if (frame_out !== last_frame) begin n_bad++; $display("[TB] FAIL nosof_dropped: got %h want %h", frame_out, last_frame); end
    for (int k = 0; k < NP; k++) f[k*PW +: PW] = PW'(k) ^ 8'hC0;
    send_frame(f, 1'b0, early);
    n_cmp++; if (early !== 1'b0) begin n_bad++; $display("[TB] FAIL nosof_early: got %b want 0", early); end
    exp_f = exp_q.pop_front();
    n_cmp++; if (frame_out !== exp_f) begin n_bad++; $display("[TB] FAIL nosof_frame: got %h want %h", frame_out, exp_f); end
    n_cmp++; if (sof_err_cnt - base !== 1) begin n_bad++; $display("[TB] FAIL nosof_err_total: got %0d want 1", sof_err_cnt - base); end
    do_ack();
    last_frame = exp_f;
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] f;
    bit early;
    int base;
    base = fv_rise_cnt;
    for (int k = 0; k < 40; k++) send_pix(PW'(k + 3), k == 0);
    rst = 1'b1; frame_ack = 1'b1;
    tick();
    rst = 1'b0; frame_ack = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
    n_cmp++; if (frame_out !== '0) begin n_bad++; $display("[TB] FAIL midfill_frame: got %h want 0", frame_out); end
    for (int i = 0; i < 100; i++) tick();
    n_cmp++; if (fv_rise_cnt !== base) begin n_bad++; $display("[TB] FAIL midfill_fv_rises: got %0d want %0d", fv_rise_cnt, base); end
    for (int k = 0; k < NP; k++) f[k*PW +: PW] = ~PW'(k);
    send_frame(f, 1'b0, early);
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL after_rst_fv: got %b want 1", frame_valid); end
    exp_f = exp_q.pop_front();
    n_cmp++; if (frame_out !== exp_f) begin n_bad++; $display("[TB] FAIL after_rst_frame: got %h want %h", frame_out, exp_f); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midfull_fv: got %b want 0", frame_valid); end
    n_cmp++; if (frame_out !== '0) begin n_bad++; $display("[TB] FAIL midfull_frame: got %h want 0", frame_out); end
    n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL midfull_ready: got %b want 1", pix_ready); end
    last_frame = '0;
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] fa;
    logic [FW-1:0] fb;
    bit early;
    int base_err;
    int base_rdy;
    for (int k = 0; k < NP; k++) begin
      fa[k*PW +: PW] = PW'(k * 3);
      fb[k*PW +: PW] = PW'(k) ^ 8'h5A;
    end
    base_err = sof_err_cnt;
`ifdef IMG_LOADER_DOUBLE_BUF_EN
    base_rdy = rdy_low_cnt;
    send_frame(fa, 1'b0, early);
    send_frame(fb, 1'b0, early);
    n_cmp++; if (rdy_low_cnt !== base_rdy) begin n_bad++; $display("[TB] FAIL b2b_ready_drop: got %0d low cycles want 0", rdy_low_cnt - base_rdy); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_ready_full: got %b want 0", pix_ready); end
    exp_f = exp_q.pop_front();
    n_cmp++; if (frame_out !== exp_f) begin n_bad++; $display("[TB] FAIL b2b_front_a: got %h want %h", frame_out, exp_f); end
    for (int i = 0; i < 100; i++) tick();
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_fv_wait: got %b want 1", frame_valid); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_ready_wait: got %b want 0", pix_ready); end
    do_ack();
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_swap_fv: got %b want 1", frame_valid); end
    exp_f = exp_q.pop_front();
    n_cmp++; if (frame_out !== exp_f) begin n_bad++; $display("[TB] FAIL b2b_front_b: got %h want %h", frame_out, exp_f); end
    do_ack();
    n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_final_fv: got %b want 0", frame_valid); end
`else
    base_rdy = 0;
    send_frame(fa, 1'b0, early);
    exp_f = exp_q.pop_front();
    // pixels offered while the frame is held must be refused
    pix_in = 8'hEE; pix_sof = 1'b1; pix_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    pix_valid = 1'b0; pix_sof = 1'b0;
    tick();
    n_cmp++; if (frame_out !== exp_f) begin n_bad++; $display("[TB] FAIL b2b_held_frame: got %h want %h", frame_out, exp_f); end
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_held_fv: got %b want 1", frame_valid); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_held_ready: got %b want 0", pix_ready); end
    do_ack();
    send_frame(fb, 1'b0, early);
    n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_second_fv: got %b want 1", frame_valid); end
    exp_f = exp_q.pop_front();
    n_cmp++; if (frame_out !== exp_f) begin n_bad++; $display("[TB] FAIL b2b_second_frame: got %h want %h", frame_out, exp_f); end
    do_ack();
`endif
    n_cmp++; if (sof_err_cnt !== base_err) begin n_bad++; $display("[TB] FAIL b2b_sof_err: got %0d pulses want 0 (rdy base %0d)", sof_err_cnt - base_err, base_rdy); end
  endtask

  initial begin
    rst = 1'b0; pix_in = '0; pix_valid = 1'b0; pix_sof = 1'b0; frame_ack = 1'b0;
    last_frame = '0;
    exp_f = '0;
    $display("[TB] img_loader bench start");
    test_reset();
    test_stream();
    test_toggle();
    test_sof_restart();
    test_no_sof();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
